bin2bcd_seq: RTL

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble). It processes one input bit per clock and is the encode-side counterpart of the BCD-to-binary decoder in the code-converter library. It uses the same start/busy/done level handshake, so the two blocks can be chained for round-trip checks. It sits between binary datapath logic and decimal display or BCD consumers.

---
 rtl/bin2bcd_seq.sv | 99 +++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one operand bit per clock.
// Latency: WIDTH+1 clocks from the accepting edge to done; repeat period WIDTH+3.
// Backpressure: start is a level request that is sampled only in IDLE/DONE; done holds until start drops.
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd_out,
    output logic                  ovf
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = DIGITS * 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PREP  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] sh;
    logic [BW-1:0]    work;
    logic [CW-1:0]    cnt;
    logic             ovf_acc;

    logic [BW-1:0]    adj;
    logic [BW-1:0]    work_nxt;
    logic [WIDTH-1:0] sh_nxt;
    logic             out_bit;
    logic [3:0]       dig;

    // Digits are corrected independently before the shift; no carry crosses a nibble.
    always_comb begin
        adj = '0;
        dig = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dig = work[i*4 +: 4];
            adj[i*4 +: 4] = (dig >= 4'd5) ? (dig + 4'd3) : dig;
        end
        {work_nxt, sh_nxt} = {adj, sh} << 1;
        out_bit = adj[BW-1];
    end

    assign busy = (state == PREP) || (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sh      <= '0;
            work    <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
            bcd_out <= '0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sh    <= bin_in;
                        state <= PREP;
                    end
                end
                PREP: begin
                    work    <= '0;
                    cnt     <= CW'(WIDTH);
                    ovf_acc <= 1'b0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    work    <= work_nxt;
                    sh      <= sh_nxt;
                    ovf_acc <= ovf_acc | out_bit;
                    cnt     <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        bcd_out <= work_nxt;
                        ovf     <= ovf_acc | out_bit;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (!start) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
